// File: rtl/mod_exp_engine.sv
// Radix-2 modular exponentiation core (result = base^exponent mod modulus).
// Square-and-multiply over an MSB-first exponent scan with a bit-serial interleaved modular multiplier.
module mod_exp_engine #(
  parameter int WIDTH      = 256,
  parameter int EXP_WIDTH  = 256,
  parameter int CONST_TIME = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     result,
  output logic                 err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [BW-1:0]    BIT_ONE  = BW'(1);
  localparam logic [BW-1:0]    BIT_LAST = BW'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ACC_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ACC_ZERO = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SQR   = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t               state_r, state_next_s;
  logic [WIDTH-1:0]     base_r, mod_r, acc_r, result_r;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [BW-1:0]        bit_cnt_r;
  logic [WIDTH-1:0]     mm_a_r, mm_b_r;
  logic [WIDTH+1:0]     mm_r_r;
  logic [CW-1:0]        mm_cnt_r;
  logic                 mm_load_r, out_valid_r, in_ready_r, err_r;

  logic                 accept_s, op_err_s, mm_last_s, cur_bit_s, last_bit_s;
  logic                 do_mul_s, advance_s, mm_start_s;
  logic [WIDTH+1:0]     mod_ext_s, t0_s, t1_s, t2_s;
  logic [WIDTH-1:0]     product_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign err       = err_r;

  // Control qualifiers derived from the current datapath state
  always_comb begin
    accept_s   = in_valid & in_ready_r;
    op_err_s   = (mod_r == ACC_ZERO) || (base_r >= mod_r);
    mm_last_s  = ~mm_load_r && (mm_cnt_r == {CW{1'b0}});
    cur_bit_s  = exp_r[EXP_WIDTH-1];
    last_bit_s = (bit_cnt_r == {BW{1'b0}});
    do_mul_s   = cur_bit_s || (CONST_TIME != 0);
    advance_s  = mm_last_s && ((state_r == MUL) || ((state_r == SQR) && !do_mul_s));
  end

  // One multiplier iteration: R = 2R + a_i*B, then up to two conditional subtractions
  always_comb begin
    mod_ext_s = {2'b00, mod_r};
    if (mm_a_r[WIDTH-1]) begin
      t0_s = (mm_r_r << 1) + {2'b00, mm_b_r};
    end else begin
      t0_s = (mm_r_r << 1);
    end
    if (t0_s >= mod_ext_s) begin
      t1_s = t0_s - mod_ext_s;
    end else begin
      t1_s = t0_s;
    end
    if (t1_s >= mod_ext_s) begin
      t2_s = t1_s - mod_ext_s;
    end else begin
      t2_s = t1_s;
    end
    product_s = t2_s[WIDTH-1:0];
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = CHECK;
        end else begin
          state_next_s = IDLE;
        end
      end
      CHECK: begin
        if (op_err_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SQR;
        end
      end
      SQR: begin
        if (!mm_last_s) begin
          state_next_s = SQR;
        end else if (do_mul_s) begin
          state_next_s = MUL;
        end else if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SQR;
        end
      end
      MUL: begin
        if (!mm_last_s) begin
          state_next_s = MUL;
        end else if (last_bit_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SQR;
        end
      end
      DONE: begin
        if (out_valid_r && out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
    mm_start_s = ((state_r == CHECK) && !op_err_s) ||
                 (mm_last_s && (state_next_s != DONE));
  end

  // State register and handshake flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      mm_load_r   <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_next_s;
      mm_load_r   <= mm_start_s;
      out_valid_r <= (state_r == DONE) && !(out_valid_r && out_ready);
      in_ready_r  <= (state_next_s == IDLE);
    end
  end

  // Operand capture, exponent scan and multiplier datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      base_r    <= ACC_ZERO;
      mod_r     <= ACC_ZERO;
      acc_r     <= ACC_ZERO;
      result_r  <= ACC_ZERO;
      err_r     <= 1'b0;
      exp_r     <= {EXP_WIDTH{1'b0}};
      bit_cnt_r <= {BW{1'b0}};
      mm_a_r    <= ACC_ZERO;
      mm_b_r    <= ACC_ZERO;
      mm_r_r    <= {(WIDTH+2){1'b0}};
      mm_cnt_r  <= {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            base_r <= base;
            exp_r  <= exponent;
            mod_r  <= modulus;
            err_r  <= 1'b0;
          end
        end
        CHECK: begin
          bit_cnt_r <= BIT_LAST;
          if (op_err_s) begin
            err_r <= 1'b1;
            acc_r <= ACC_ZERO;
          end else if (mod_r == ACC_ONE) begin
            acc_r <= ACC_ZERO;
          end else begin
            acc_r <= ACC_ONE;
          end
        end
        SQR, MUL: begin
          if (mm_load_r) begin
            mm_a_r   <= acc_r;
            mm_b_r   <= (state_r == SQR) ? acc_r : base_r;
            mm_r_r   <= {(WIDTH+2){1'b0}};
            mm_cnt_r <= CNT_LAST;
          end else begin
            mm_r_r   <= t2_s;
            mm_a_r   <= mm_a_r << 1;
            mm_cnt_r <= mm_cnt_r - CNT_ONE;
          end
          // Dummy multiply in constant-time mode leaves acc untouched on 0-bits
          if (mm_last_s && ((state_r == SQR) || cur_bit_s)) begin
            acc_r <= product_s;
          end
          if (advance_s) begin
            exp_r     <= exp_r << 1;
            bit_cnt_r <= bit_cnt_r - BIT_ONE;
          end
        end
        DONE: begin
          if (!out_valid_r) begin
            result_r <= acc_r;
          end
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_engine.sv
// Directed bench for mod_exp_engine (WIDTH=16, EXP_WIDTH=16): vector table plus
// hand-written backpressure, reset-abort and variable-time latency sequences.
module tb_mod_exp_engine;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [15:0] base, exponent, modulus, result;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, err0;
  logic [15:0] result0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] b;
    logic [15:0] e;
    logic [15:0] m;
    logic [15:0] res;
    logic        er;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16), .CONST_TIME(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .base(base), .exponent(exponent), .modulus(modulus),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err)
  );

  mod_exp_engine #(.WIDTH(16), .EXP_WIDTH(16), .CONST_TIME(0)) dut_vt (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .base(base), .exponent(exponent), .modulus(modulus),
    .out_valid(out_valid0), .out_ready(out_ready0), .result(result0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand set to the constant-time engine and wait for out_valid
  task automatic do_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                       output logic [15:0] res, output logic er, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 2000) begin
      tick();
      guard++;
    end
    check("ready_before_issue", 32'(in_ready), 32'd1);
    base = b; exponent = e; modulus = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("in_ready_low_after_accept", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 2000) begin
      tick();
      lat++;
    end
    res = result;
    er  = err;
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_restored"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] res;
    logic        er;
    int          lat;
    int          guard;

    vecs[0] = '{b:16'd4,    e:16'd13,   m:16'd497,  res:16'd445,  er:1'b0, lat:546};
    vecs[1] = '{b:16'd65,   e:16'd17,   m:16'd3233, res:16'd2790, er:1'b0, lat:546};
    vecs[2] = '{b:16'd2790, e:16'd2753, m:16'd3233, res:16'd65,   er:1'b0, lat:546};
    vecs[3] = '{b:16'd7,    e:16'd0,    m:16'd11,   res:16'd1,    er:1'b0, lat:546};
    vecs[4] = '{b:16'd0,    e:16'd3,    m:16'd1,    res:16'd0,    er:1'b0, lat:546};
    vecs[5] = '{b:16'd0,    e:16'd5,    m:16'd11,   res:16'd0,    er:1'b0, lat:546};
    vecs[6] = '{b:16'd5,    e:16'd3,    m:16'd0,    res:16'd0,    er:1'b1, lat:2};
    vecs[7] = '{b:16'd3233, e:16'd1,    m:16'd3233, res:16'd0,    er:1'b1, lat:2};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0;
    base = 16'd0; exponent = 16'd0; modulus = 16'd0;
    tick(); tick();
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    reset = 1'b1;
    tick();

    // Table vectors; entries 1 and 2 form the back-to-back RSA encrypt/decrypt pair
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].b, vecs[i].e, vecs[i].m, res, er, lat);
      check($sformatf("v%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].er));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      release_result($sformatf("v%0d", i));
    end

    // Backpressure: result held, new operands ignored while waiting
    do_op(16'd4, 16'd13, 16'd497, res, er, lat);
    base = 16'd2; exponent = 16'd3; modulus = 16'd5; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_result", k), 32'(result), 32'd445);
      check($sformatf("bp%0d_err", k), 32'(err), 32'd0);
      check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_result("bp");
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_not_queued%0d", k), 32'(out_valid), 32'd0);
    end

    // Reset pulse in the middle of the first square aborts the operation
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    guard = 0;
    while (!out_valid && guard < 600) begin
      tick();
      guard++;
    end
    check("abort_no_output", 32'(out_valid), 32'd0);
    do_op(16'd4, 16'd13, 16'd497, res, er, lat);
    check("reissue_result", 32'(res), 32'd445);
    check("reissue_err", 32'(er), 32'd0);
    check("reissue_latency", 32'(lat), 32'd546);
    release_result("reissue");

    // Variable-time engine: latency depends on exponent popcount
    check("vt_ready", 32'(in_ready0), 32'd1);
    base = 16'd4; exponent = 16'd13; modulus = 16'd497; in_valid0 = 1'b1;
    tick();
    in_valid0 = 1'b0;
    lat = 0;
    while (!out_valid0 && lat < 2000) begin
      tick();
      lat++;
    end
    check("vt_latency", 32'(lat), 32'd325);
    check("vt_result", 32'(result0), 32'd445);
    check("vt_err", 32'(err0), 32'd0);
    out_ready0 = 1'b1;
    tick();
    out_ready0 = 1'b0;
    check("vt_out_valid_cleared", 32'(out_valid0), 32'd0);
    check("vt_in_ready_restored", 32'(in_ready0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
